// File: rtl/stim_shift_driver.sv
// Serial stimulus stage: shifts a loaded pattern out LSB-first on x, one bit per clock,
// samples the downstream machine's F once per bit period and counts the F=1 samples.
module stim_shift_driver #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic             hold,
  input  logic             F,
  output logic             x,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] resp,
  output logic [LEN_W-1:0] ones_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a level request sampled only in IDLE; busy is high for exactly
  // one cycle per bit period (plus any hold cycles); done and err are single-cycle pulses.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  state_t           state_q, state_d;
  logic             x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] resp_q, resp_d;
  logic [LEN_W-1:0] ones_q, ones_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bit_idx;
  logic             len_legal;

  assign len_legal = (length != '0) && (length <= MAX_LEN);
  // Bit period index counts up while remaining counts down.
  assign bit_idx   = len_q - rem_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    resp_d  = resp_q;
    ones_d  = ones_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        x_d    = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          if (len_legal) begin
            x_d     = pattern[0];
            shreg_d = pattern >> 1;
            rem_d   = length;
            len_d   = length;
            resp_d  = '0;
            ones_d  = '0;
            busy_d  = 1'b1;
            state_d = SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (!hold) begin
          resp_d = resp_q | ({{(WIDTH-1){1'b0}}, F} << bit_idx);
          ones_d = ones_q + {{(LEN_W-1){1'b0}}, F};
          if (rem_q > ONE_LEN) begin
            x_d     = shreg_q[0];
            shreg_d = shreg_q >> 1;
            rem_d   = rem_q - ONE_LEN;
          end else begin
            x_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        x_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      resp_q  <= '0;
      ones_q  <= '0;
      shreg_q <= '0;
      rem_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      ones_q  <= ones_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
    end
  end

  assign x         = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign resp      = resp_q;
  assign ones_cnt  = ones_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stim_shift_driver.sv
// Directed bench for stim_shift_driver: reset, basic send, loopback, hold, illegal length, abort.
module tb_stim_shift_driver;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic             hold;
  logic             f_drv;
  logic             f_loop_q;
  logic             loop_mode;
  logic             f_in;
  logic             x;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] resp;
  logic [LEN_W-1:0] ones_cnt;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errs   = 0;
  int busy_cnt;
  int done_cnt;

  stim_shift_driver #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .CLK      (clk),
    .RESET    (reset),
    .start    (start),
    .pattern  (pattern),
    .length   (length),
    .hold     (hold),
    .F        (f_in),
    .x        (x),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .resp     (resp),
    .ones_cnt (ones_cnt),
    .dbg_state(dbg_state)
  );

  // Clock and the one-cycle loopback register standing in for the downstream machine.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) f_loop_q <= x;
  assign f_in = loop_mode ? f_loop_q : f_drv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_x"},    32'(x), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"},  32'(err), 32'd0);
    check({tag, "_resp"}, 32'(resp), 32'd0);
    check({tag, "_ones"}, 32'(ones_cnt), 32'd0);
    check({tag, "_st"},   32'(dbg_state), 32'd0);
  endtask

  initial begin
    logic [3:0] basic_x;
    logic [7:0] hold_x;
    logic [WIDTH-1:0] lb_pat;

    reset = 1'b1; start = 1'b0; pattern = '0; length = '0;
    hold = 1'b0; f_drv = 1'b0; loop_mode = 1'b0; f_loop_q = 1'b0;

    // Reset while idle, two cycles.
    tick();
    check_idle_zero("rst1");
    tick();
    check_idle_zero("rst2");
    reset = 1'b0;
    tick();

    // Basic: 0x0005, length 4, F tied high.
    basic_x = 4'b0101;
    pattern = 16'h0005; length = 5'd4; f_drv = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("basic_x%0d", k), 32'(x), 32'(basic_x[k]));
      check($sformatf("basic_busy%0d", k), 32'(busy), 32'd1);
      check($sformatf("basic_done%0d", k), 32'(done), 32'd0);
      tick();
    end
    check("basic_done", 32'(done), 32'd1);
    check("basic_busy_end", 32'(busy), 32'd0);
    check("basic_x_end", 32'(x), 32'd0);
    check("basic_st_done", 32'(dbg_state), 32'd2);
    check("basic_resp", 32'(resp), 32'h000F);
    check("basic_ones", 32'(ones_cnt), 32'd4);
    tick();
    check("basic_done_clr", 32'(done), 32'd0);
    check("basic_st_idle", 32'(dbg_state), 32'd0);

    // Loopback: F is x delayed one clock, start held high until done is seen.
    lb_pat = 16'hA5C3;
    loop_mode = 1'b1; pattern = lb_pat; length = 5'd16; start = 1'b1;
    tick();
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 16) check($sformatf("lb_x%0d", i), 32'(x), 32'(lb_pat[i]));
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        start = 1'b0;
      end
      tick();
    end
    check("lb_busy_cycles", 32'(busy_cnt), 32'd16);
    check("lb_done_pulses", 32'(done_cnt), 32'd1);
    check("lb_resp", 32'(resp), 32'h4B86);
    check("lb_ones", 32'(ones_cnt), 32'd7);
    start = 1'b0; loop_mode = 1'b0;

    // Hold for 3 cycles starting in bit period 2.
    hold_x = 8'b0011_1101;
    pattern = 16'h0005; length = 5'd4; f_drv = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int e = 0; e < 8; e++) begin
      check($sformatf("hold_x%0d", e), 32'(x), 32'(hold_x[e]));
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (e == 2) hold = 1'b1;
      if (e == 5) hold = 1'b0;
      if (e < 7) tick();
    end
    check("hold_done", 32'(done), 32'd1);
    check("hold_busy_cycles", 32'(busy_cnt), 32'd7);
    check("hold_done_pulses", 32'(done_cnt), 32'd1);
    check("hold_resp", 32'(resp), 32'h000F);
    check("hold_ones", 32'(ones_cnt), 32'd4);
    tick();
    tick();

    // Illegal lengths 0 and 17; previous results must survive.
    start = 1'b1; length = 5'd0;
    tick();
    start = 1'b0;
    check("ill0_err", 32'(err), 32'd1);
    check("ill0_busy", 32'(busy), 32'd0);
    check("ill0_resp", 32'(resp), 32'h000F);
    check("ill0_ones", 32'(ones_cnt), 32'd4);
    tick();
    check("ill0_err_clr", 32'(err), 32'd0);
    start = 1'b1; length = 5'd17;
    tick();
    start = 1'b0;
    check("ill17_err", 32'(err), 32'd1);
    check("ill17_busy", 32'(busy), 32'd0);
    check("ill17_st", 32'(dbg_state), 32'd0);
    check("ill17_resp", 32'(resp), 32'h000F);
    check("ill17_ones", 32'(ones_cnt), 32'd4);
    tick();
    check("ill17_err_clr", 32'(err), 32'd0);

    // Abort: reset during bit period 3 of a length-8 run.
    pattern = 16'h00FF; length = 5'd8; f_drv = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_zero("abort");
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) done_cnt++;
      tick();
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // Legal run after the abort.
    pattern = 16'h0001; length = 5'd2; f_drv = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("rerun_x0", 32'(x), 32'd1);
    tick();
    check("rerun_x1", 32'(x), 32'd0);
    check("rerun_busy1", 32'(busy), 32'd1);
    tick();
    check("rerun_done", 32'(done), 32'd1);
    check("rerun_resp", 32'(resp), 32'h0003);
    check("rerun_ones", 32'(ones_cnt), 32'd2);
    tick();

    // Reset after a completed run clears the held results.
    reset = 1'b1;
    tick();
    check_idle_zero("rst_after");
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
